audio_codec_i2s: RTL
====================

Name: audio_codec_i2s

Overview:
- Downstream stage of the sample-playback block: serialises 16-bit mono samples to the audio codec DAC over I2S, and captures 16-bit ADC samples.
- Codec runs in slave mode; this block is I2S master and generates BCLK, DACLRCK and ADCLRCK from clk.
- Issues one sample_req pulse per channel slot and latches audio_output exactly one clk after that pulse (the upstream block holds its data for one cycle only).
- Exposes the captured ADC word with a sample_end pulse.

Parameters:
- HALF_BCLK_DIV, 2, clk cycles per BCLK half-period (≥2).
- BITS_PER_CH, 32, BCLK periods per channel slot (≥18).
- DATA_W, 16, sample width.

Ports:
- clk  in  1  audio clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sample_req  out  1  one-cycle pulse requesting the next sample.
- channel_sel  out  1  channel of the requested sample (0=left, 1=right); valid while sample_req is high, held until the next request.
- audio_output  in  DATA_W  sample from upstream; sampled in the cycle after sample_req.
- mute  in  1  when high at latch time, zero is latched instead of audio_output.
- sample_end  out  1  one-cycle pulse: audio_sample updated.
- audio_sample  out  DATA_W  last captured ADC word.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  DAC word select (0=left).
- AUD_ADCLRCK  out  1  ADC word select; identical to AUD_DACLRCK.
- AUD_DACDAT  out  1  serial DAC data.
- AUD_ADCDAT  in  1  serial ADC data.

Behaviour:
- Reset, synchronous: all outputs 0; div_cnt=0, slot=0, hold_reg=0, shift regs=0. Reset mid-frame aborts immediately. The next frame starts at left, slot 0.
- div_cnt counts 0..HALF_BCLK_DIV-1. At terminal count BCLK toggles. A toggle 1→0 is a "fall", and a toggle 0→1 is a "rise". All outputs are registered.
- At each fall, slot increments 0..BITS_PER_CH-1. At wrap, slot returns to 0 and LRCK toggles in the same cycle.
- sample_req is high for exactly one clk, in the cycle the fall into slot BITS_PER_CH-1 becomes visible. channel_sel is set to ~LRCK in that cycle.
- Latch: in the cycle after sample_req, hold_reg <= mute ? 0 : audio_output. This is the only capture point; audio_output is ignored in all other cycles.
- DAC, I2S one-bit delay, data changes on falls:
  - At the LRCK-toggle fall, dac_shift <= hold_reg and DACDAT=0 for slot 0.
  - Slots 1..DATA_W drive dac_shift MSB-first, shifting at each fall.
  - Slots DATA_W+1..BITS_PER_CH-1 drive 0.
- ADC: at each rise in slots 1..DATA_W, adc_shift <= {adc_shift, ADCDAT}. At the rise in slot DATA_W+1, audio_sample <= adc_shift and sample_end pulses for one clk.
- Default timing: frame = 2·BITS_PER_CH·2·HALF_BCLK_DIV = 256 clk, i.e. 128 clk per channel. sample_req occurs every 128 clk, 4 clk before each LRCK edge.
- The first left slot after reset transmits zeros because hold_reg is 0.
- The first sample_req (channel_sel=1) is at cycle 124 after reset deasserts, and the first LRCK rise is at cycle 128.
- Simultaneous events: the sample_req cycle and the latch cycle never coincide with an LRCK toggle, because the guaranteed gap is ≥2·HALF_BCLK_DIV clk.

Decomposition:
- Package audio_pkg:
  - localparams DATA_W, BITS_PER_CH, HALF_BCLK_DIV defaults.
  - typedef sample_t (logic [DATA_W-1:0]).
  - enum chan_e {CH_LEFT=0, CH_RIGHT=1}.
- Sub-module audio_bclk_gen: div_cnt, BCLK, slot counter and LRCK. Outputs are single-cycle fall/rise strobes, slot and lrck. The top level holds the latch, the DAC/ADC shift registers and sample_req.

Test Plan:
- Reset, then 512 clk free-run → BCLK period 4 clk; LRCK period 256 clk with first rise at cycle 128; sample_req at cycles 124, 252, 380, 508; channel_sel 1,0,1,0.
- Upstream model drives 16'hA5C3 only in the cycle after each request → DACDAT bits in slots 1..16 of the next slot = 1010_0101_1100_0011; slot 0 and slots 17..31 = 0.
- Left sample 16'h8001, right sample 16'h7FFE → decoded I2S frame L=8001, R=7FFE; LRCK=0 during the left slot.
- mute=1 during the latch cycle while audio_output=16'hFFFF → that slot's DACDAT is all 0; the next unmuted slot is correct.
- Codec model drives ADCDAT=16'h3C5A MSB-first from slot 1 → audio_sample=16'h3C5A with one sample_end pulse per channel, at the rise of slot 17.
- Reset asserted at cycle 70 for 3 cycles → all outputs 0 the cycle after reset is sampled; the timing in the first scenario restarts relative to the release.

Source files
------------

// File: rtl/audio_codec_i2s_pkg.sv
// audio_pkg: shared widths, sample type and channel encoding for the I2S codec link.
package audio_pkg;
  localparam int DATA_W = 16;
  localparam int BITS_PER_CH = 32;
  localparam int HALF_BCLK_DIV = 2;
  typedef logic [DATA_W-1:0] sample_t;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} chan_e;
endpackage

// File: rtl/audio_codec_i2s_if.sv
// audio_codec_i2s_if: sample handshake between the playback/capture logic and the I2S master.
interface audio_codec_i2s_if #(parameter int DATA_W = audio_pkg::DATA_W);
  logic sample_req;
  logic channel_sel;
  logic [DATA_W-1:0] audio_output;
  logic mute;
  logic sample_end;
  logic [DATA_W-1:0] audio_sample;
  modport master(output sample_req, channel_sel, sample_end, audio_sample, input audio_output, mute);
  modport slave(input sample_req, channel_sel, sample_end, audio_sample, output audio_output, mute);
endinterface

// File: rtl/audio_codec_i2s_bclk_gen.sv
// audio_bclk_gen: BCLK divider, slot counter and LRCK; o_fall/o_rise flag the clk edge on which BCLK changes.
module audio_bclk_gen #(
  parameter int HALF_BCLK_DIV = 2,
  parameter int BITS_PER_CH = 32,
  parameter int SLOT_W = $clog2(BITS_PER_CH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              o_fall,
  output logic              o_rise,
  output logic              o_bclk,
  output logic              o_lrck,
  output logic [SLOT_W-1:0] o_slot
);
  localparam int DIV_W = HALF_BCLK_DIV > 1 ? $clog2(HALF_BCLK_DIV) : 1;
  logic [DIV_W-1:0] r_div;
  logic [SLOT_W-1:0] r_slot;
  logic r_bclk, r_lrck;
  logic w_tc, w_wrap;
  assign w_tc = r_div == DIV_W'(HALF_BCLK_DIV - 1);
  assign w_wrap = r_slot == SLOT_W'(BITS_PER_CH - 1);
  assign o_fall = w_tc & r_bclk;
  assign o_rise = w_tc & ~r_bclk;
  assign o_bclk = r_bclk;
  assign o_lrck = r_lrck;
  assign o_slot = r_slot;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_bclk <= 1'b0;
      r_slot <= '0;
      r_lrck <= 1'b0;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      r_bclk <= r_bclk ^ w_tc;
      r_slot <= o_fall ? (w_wrap ? '0 : r_slot + 1'b1) : r_slot;
      r_lrck <= r_lrck ^ (o_fall & w_wrap);
    end
  end
endmodule

// File: rtl/audio_codec_i2s.sv
// audio_codec_i2s: I2S master serialising DAC samples and capturing ADC words from a slave-mode codec.
module audio_codec_i2s #(
  parameter int HALF_BCLK_DIV = audio_pkg::HALF_BCLK_DIV,
  parameter int BITS_PER_CH = audio_pkg::BITS_PER_CH,
  parameter int DATA_W = audio_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  audio_codec_i2s_if.master    bus,
  output logic                 AUD_BCLK,
  output logic                 AUD_DACLRCK,
  output logic                 AUD_ADCLRCK,
  output logic                 AUD_DACDAT,
  input  logic                 AUD_ADCDAT
);
  import audio_pkg::*;
  localparam int SLOT_W = $clog2(BITS_PER_CH);
  logic w_fall, w_rise, w_bclk, w_lrck;
  logic [SLOT_W-1:0] w_slot;
  logic w_req_slot, w_last, w_dac_bit, w_adc_bit, w_adc_done;
  logic r_sample_req, r_latch, r_sample_end, r_dacdat;
  chan_e r_channel_sel;
  logic [DATA_W-1:0] r_hold, r_dac_shift, r_adc_shift, r_audio_sample;
  audio_bclk_gen #(.HALF_BCLK_DIV(HALF_BCLK_DIV), .BITS_PER_CH(BITS_PER_CH), .SLOT_W(SLOT_W)) u_bclk (
    .clk(clk), .reset(reset), .o_fall(w_fall), .o_rise(w_rise), .o_bclk(w_bclk), .o_lrck(w_lrck), .o_slot(w_slot)
  );
  assign w_req_slot = w_slot == SLOT_W'(BITS_PER_CH - 2);
  assign w_last = w_slot == SLOT_W'(BITS_PER_CH - 1);
  assign w_dac_bit = w_slot < SLOT_W'(DATA_W);
  assign w_adc_bit = w_slot != '0 && w_slot <= SLOT_W'(DATA_W);
  assign w_adc_done = w_slot == SLOT_W'(DATA_W + 1);
  // Slot 0 of each channel idles at 0 while the held word loads: the I2S one-bit delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample_req <= 1'b0;
      r_latch <= 1'b0;
      r_sample_end <= 1'b0;
      r_dacdat <= 1'b0;
      r_channel_sel <= CH_LEFT;
      r_hold <= '0;
      r_dac_shift <= '0;
      r_adc_shift <= '0;
      r_audio_sample <= '0;
    end else begin
      r_sample_req <= w_fall & w_req_slot;
      r_latch <= r_sample_req;
      r_sample_end <= w_rise & w_adc_done;
      if (w_fall & w_req_slot) r_channel_sel <= w_lrck ? CH_LEFT : CH_RIGHT;
      if (r_latch) r_hold <= bus.mute ? '0 : bus.audio_output;
      if (w_fall) begin
        r_dac_shift <= w_last ? r_hold : (w_dac_bit ? r_dac_shift << 1 : r_dac_shift);
        r_dacdat <= !w_last && w_dac_bit && r_dac_shift[DATA_W-1];
      end
      if (w_rise & w_adc_bit) r_adc_shift <= {r_adc_shift[DATA_W-2:0], AUD_ADCDAT};
      if (w_rise & w_adc_done) r_audio_sample <= r_adc_shift;
    end
  end
  assign bus.sample_req = r_sample_req;
  assign bus.channel_sel = r_channel_sel;
  assign bus.sample_end = r_sample_end;
  assign bus.audio_sample = r_audio_sample;
  assign AUD_BCLK = w_bclk;
  assign AUD_DACLRCK = w_lrck;
  assign AUD_ADCLRCK = w_lrck;
  assign AUD_DACDAT = r_dacdat;
endmodule
